// File: rtl/wb_regfile_if.sv
// Writeback-stage bus: MEM/WB register outputs, data-memory return, ID read
// ports, stall request and commit trace.
interface wb_regfile_if #(parameter int XLEN = 32);
    logic [4:0]      wb_rd;
    logic            wb_wreg;
    logic            wb_mem2reg;
    logic [XLEN-1:0] wb_from_alu;
    logic [2:0]      wb_func3;
    logic [XLEN-1:0] dm_rdata;
    logic            dm_rvalid;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic            stall_req;
    logic            trace_valid;
    logic [4:0]      trace_rd;
    logic [XLEN-1:0] trace_data;

    modport master (
        output wb_rd, wb_wreg, wb_mem2reg, wb_from_alu, wb_func3,
        output dm_rdata, dm_rvalid, rs1_addr, rs2_addr,
        input  rs1_data, rs2_data, stall_req, trace_valid, trace_rd, trace_data
    );

    modport slave (
        input  wb_rd, wb_wreg, wb_mem2reg, wb_from_alu, wb_func3,
        input  dm_rdata, dm_rvalid, rs1_addr, rs2_addr,
        output rs1_data, rs2_data, stall_req, trace_valid, trace_rd, trace_data
    );
endinterface

// File: rtl/wb_regfile.sv
// Writeback stage and integer register file: load formatting, GPR commit,
// two bypassed read ports, load-wait stall request and commit trace.
module wb_regfile #(
    parameter int XLEN    = 32,
    parameter int REG_NUM = 32,
    parameter int BYPASS  = 1
) (
    input logic        clk,
    input logic        rst,
    wb_regfile_if.slave bus
);
    localparam logic [5:0] NREG = 6'(REG_NUM);

    logic [XLEN-1:0] gpr [REG_NUM];
    logic [1:0]      off;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] load_data;
    logic [XLEN-1:0] wdata;
    logic            load_wait;
    logic            commit;

    always_comb begin
        off = bus.wb_from_alu[1:0];
        case (off)
            2'd0:    ld_byte = bus.dm_rdata[7:0];
            2'd1:    ld_byte = bus.dm_rdata[15:8];
            2'd2:    ld_byte = bus.dm_rdata[23:16];
            default: ld_byte = bus.dm_rdata[31:24];
        endcase
        ld_half = off[1] ? bus.dm_rdata[31:16] : bus.dm_rdata[15:0];
        // Undefined width codes fall back to a full-word load.
        case (bus.wb_func3)
            3'b000:  load_data = {{(XLEN-8){ld_byte[7]}}, ld_byte};
            3'b100:  load_data = {{(XLEN-8){1'b0}}, ld_byte};
            3'b001:  load_data = {{(XLEN-16){ld_half[15]}}, ld_half};
            3'b101:  load_data = {{(XLEN-16){1'b0}}, ld_half};
            default: load_data = bus.dm_rdata;
        endcase
    end

    assign wdata         = bus.wb_mem2reg ? load_data : bus.wb_from_alu;
    assign load_wait     = bus.wb_mem2reg & ~bus.dm_rvalid;
    assign commit        = bus.wb_wreg & (bus.wb_rd != 5'd0) & ~load_wait;
    assign bus.stall_req = load_wait;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_NUM; i++) gpr[i] <= '0;
        end else if (commit && ({1'b0, bus.wb_rd} < NREG)) begin
            gpr[bus.wb_rd] <= wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.trace_valid <= 1'b0;
            bus.trace_rd    <= '0;
            bus.trace_data  <= '0;
        end else begin
            bus.trace_valid <= commit;
            if (commit) begin
                bus.trace_rd   <= bus.wb_rd;
                bus.trace_data <= wdata;
            end
        end
    end

    // x0 reads as zero even though gpr[0] is only ever cleared.
    always_comb begin
        bus.rs1_data = '0;
        if (bus.rs1_addr != 5'd0) begin
            if (BYPASS != 0 && commit && bus.rs1_addr == bus.wb_rd)
                bus.rs1_data = wdata;
            else if ({1'b0, bus.rs1_addr} < NREG)
                bus.rs1_data = gpr[bus.rs1_addr];
        end
    end

    always_comb begin
        bus.rs2_data = '0;
        if (bus.rs2_addr != 5'd0) begin
            if (BYPASS != 0 && commit && bus.rs2_addr == bus.wb_rd)
                bus.rs2_data = wdata;
            else if ({1'b0, bus.rs2_addr} < NREG)
                bus.rs2_data = gpr[bus.rs2_addr];
        end
    end
endmodule

// File: tb/tb_wb_regfile.sv
// Randomized and directed bench for wb_regfile; a BYPASS=1 and a BYPASS=0
// instance share the same stimulus and are checked against an array model.
module tb_wb_regfile;
    localparam int XLEN = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    wb_regfile_if #(.XLEN(XLEN)) bus1 ();
    wb_regfile_if #(.XLEN(XLEN)) bus0 ();

    assign bus0.wb_rd       = bus1.wb_rd;
    assign bus0.wb_wreg     = bus1.wb_wreg;
    assign bus0.wb_mem2reg  = bus1.wb_mem2reg;
    assign bus0.wb_from_alu = bus1.wb_from_alu;
    assign bus0.wb_func3    = bus1.wb_func3;
    assign bus0.dm_rdata    = bus1.dm_rdata;
    assign bus0.dm_rvalid   = bus1.dm_rvalid;
    assign bus0.rs1_addr    = bus1.rs1_addr;
    assign bus0.rs2_addr    = bus1.rs2_addr;

    wb_regfile #(.XLEN(XLEN), .REG_NUM(32), .BYPASS(1)) dut1 (.clk(clk), .rst(rst), .bus(bus1));
    wb_regfile #(.XLEN(XLEN), .REG_NUM(32), .BYPASS(0)) dut0 (.clk(clk), .rst(rst), .bus(bus0));

    int total = 0;
    int bad   = 0;

    logic [31:0] ref_gpr [32];
    logic        ref_tv;
    logic [4:0]  ref_trd;
    logic [31:0] ref_tdata;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] fmt_load(input logic [2:0] f3, input logic [1:0] off,
                                             input logic [31:0] w);
        logic [31:0] v;
        case (f3)
            3'd0, 3'd4: begin
                v = (w >> (8 * int'(off))) & 32'hFF;
                if (f3 == 3'd0 && v >= 32'h80) v = v - 32'h100;
            end
            3'd1, 3'd5: begin
                v = (w >> (16 * int'(off[1]))) & 32'hFFFF;
                if (f3 == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    function automatic logic [31:0] exp_wdata();
        return bus1.wb_mem2reg ? fmt_load(bus1.wb_func3, bus1.wb_from_alu[1:0], bus1.dm_rdata)
                               : bus1.wb_from_alu;
    endfunction

    function automatic bit exp_stall();
        return bus1.wb_mem2reg && !bus1.dm_rvalid;
    endfunction

    function automatic bit exp_commit();
        return bus1.wb_wreg && bus1.wb_rd != 5'd0 && !exp_stall();
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] a, input bit byp);
        if (a == 5'd0) return 32'h0;
        if (byp && exp_commit() && a == bus1.wb_rd) return exp_wdata();
        return ref_gpr[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) ref_gpr[i] = 32'h0;
        ref_tv = 1'b0; ref_trd = 5'd0; ref_tdata = 32'h0;
    endtask

    // Inputs are already driven (just after a negedge); check, clock, check trace.
    task automatic step();
        logic [31:0] wd;
        bit cm;
        #1;
        wd = exp_wdata();
        cm = exp_commit();
        chk("rs1_byp", bus1.rs1_data, exp_read(bus1.rs1_addr, 1'b1));
        chk("rs2_byp", bus1.rs2_data, exp_read(bus1.rs2_addr, 1'b1));
        chk("rs1_nobyp", bus0.rs1_data, exp_read(bus1.rs1_addr, 1'b0));
        chk("rs2_nobyp", bus0.rs2_data, exp_read(bus1.rs2_addr, 1'b0));
        chk("stall", 32'(bus1.stall_req), 32'(exp_stall()));
        @(posedge clk);
        ref_tv = cm;
        if (cm) begin
            ref_gpr[bus1.wb_rd] = wd;
            ref_trd   = bus1.wb_rd;
            ref_tdata = wd;
        end
        #1;
        chk("trace_valid", 32'(bus1.trace_valid), 32'(ref_tv));
        chk("trace_rd", 32'(bus1.trace_rd), 32'(ref_trd));
        chk("trace_data", bus1.trace_data, ref_tdata);
        chk("trace_valid_nb", 32'(bus0.trace_valid), 32'(ref_tv));
        @(negedge clk);
    endtask

    task automatic bubble();
        bus1.wb_rd = 5'd0; bus1.wb_wreg = 1'b0; bus1.wb_mem2reg = 1'b0;
        bus1.wb_from_alu = 32'h0; bus1.wb_func3 = 3'd0; bus1.dm_rvalid = 1'b0;
    endtask

    task automatic alu_wr(input logic [4:0] rd, input logic [31:0] v);
        bus1.wb_rd = rd; bus1.wb_wreg = 1'b1; bus1.wb_mem2reg = 1'b0;
        bus1.wb_from_alu = v; bus1.dm_rvalid = 1'b0;
    endtask

    task automatic load(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off,
                        input logic [31:0] w, input logic vld);
        bus1.wb_rd = rd; bus1.wb_wreg = 1'b1; bus1.wb_mem2reg = 1'b1; bus1.wb_func3 = f3;
        bus1.wb_from_alu = {$urandom_range(0, 255), 6'b0, off};
        bus1.dm_rdata = w; bus1.dm_rvalid = vld;
    endtask

    logic [2:0]  lf3 [6] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b110};
    logic [1:0]  loff[6] = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd1, 2'd2};
    logic [31:0] lexp[6] = '{32'hFFFFFF80, 32'h0000007F, 32'hFFFF80FF,
                             32'h00007F01, 32'h80FF7F01, 32'h80FF7F01};

    initial begin
        int stalls;
        int waitn;
        rst = 1'b1;
        bubble();
        bus1.dm_rdata = 32'h0; bus1.rs1_addr = 5'd0; bus1.rs2_addr = 5'd0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_trace_valid", 32'(bus1.trace_valid), 32'h0);
        chk("rst_trace_data", bus1.trace_data, 32'h0);
        rst = 1'b0;

        // Reset test: write x5, then async reset mid-cycle.
        alu_wr(5'd5, 32'hDEADBEEF); bus1.rs1_addr = 5'd5;
        step();
        bubble();
        #1 chk("x5_written", bus1.rs1_data, 32'hDEADBEEF);
        #1 rst = 1'b1;
        #1 chk("x5_after_rst", bus1.rs1_data, 32'h0);
        chk("tv_after_rst", 32'(bus1.trace_valid), 32'h0);
        model_reset();
        #1 rst = 1'b0;
        @(negedge clk);

        // ALU writeback with same-cycle bypass on both ports.
        alu_wr(5'd7, 32'h12345678); bus1.rs1_addr = 5'd7; bus1.rs2_addr = 5'd7;
        #1 chk("alu_byp_rs1", bus1.rs1_data, 32'h12345678);
        chk("alu_byp_rs2", bus1.rs2_data, 32'h12345678);
        step();
        bubble();
        chk("alu_tv", 32'(bus1.trace_valid), 32'h1);
        chk("alu_trd", 32'(bus1.trace_rd), 32'd7);
        #1 chk("alu_arr_rs1", bus1.rs1_data, 32'h12345678);
        chk("alu_arr_rs2", bus1.rs2_data, 32'h12345678);
        step();

        // Load formatting table.
        bus1.rs1_addr = 5'd3; bus1.rs2_addr = 5'd0;
        for (int i = 0; i < 6; i++) begin
            load(5'd3, lf3[i], loff[i], 32'h80FF7F01, 1'b1);
            #1 chk($sformatf("fmt%0d", i), bus1.rs1_data, lexp[i]);
            step();
        end

        // Load wait: three stall cycles, then one commit.
        bubble(); bus1.rs1_addr = 5'd9;
        step();
        stalls = 0;
        load(5'd9, 3'b010, 2'd0, 32'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            bus1.dm_rdata = $urandom;
            #1 if (bus1.stall_req) stalls++;
            step();
            chk("wait_no_trace", 32'(bus1.trace_valid), 32'h0);
        end
        chk("wait_stall_cycles", 32'(stalls), 32'd3);
        bus1.dm_rdata = 32'hA5; bus1.dm_rvalid = 1'b1;
        #1 chk("wait_release", 32'(bus1.stall_req), 32'h0);
        step();
        chk("wait_tv", 32'(bus1.trace_valid), 32'h1);
        bubble();
        #1 chk("x9_val", bus0.rs1_data, 32'hA5);
        step();
        chk("wait_tv_once", 32'(bus1.trace_valid), 32'h0);

        // x0 protection.
        alu_wr(5'd0, 32'hFFFFFFFF); bus1.rs1_addr = 5'd0;
        #1 chk("x0_read", bus1.rs1_data, 32'h0);
        step();
        chk("x0_tv", 32'(bus1.trace_valid), 32'h0);
        load(5'd0, 3'b010, 2'd0, 32'h1234, 1'b0);
        #1 chk("x0_load_stall", 32'(bus1.stall_req), 32'h1);
        step();

        // BYPASS=0 sees the old value during the write cycle.
        alu_wr(5'd4, 32'h11); bus1.rs2_addr = 5'd4;
        step();
        alu_wr(5'd4, 32'h55);
        #1 chk("nb_old", bus0.rs2_data, 32'h11);
        chk("b_new", bus1.rs2_data, 32'h55);
        step();
        bubble();
        #1 chk("nb_new", bus0.rs2_data, 32'h55);
        step();

        // Randomized traffic; loads are held through a random wait.
        for (int n = 0; n < 250; n++) begin
            bus1.rs1_addr = 5'($urandom_range(0, 31));
            bus1.rs2_addr = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 5) == 0) begin
                bubble();
                step();
            end else if ($urandom_range(0, 1) == 0) begin
                alu_wr(5'($urandom_range(0, 31)), $urandom);
                bus1.wb_wreg = ($urandom_range(0, 7) != 0);
                bus1.dm_rvalid = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 2) == 0) bus1.rs1_addr = bus1.wb_rd;
                if ($urandom_range(0, 2) == 0) bus1.rs2_addr = bus1.wb_rd;
                step();
            end else begin
                waitn = $urandom_range(0, 3);
                load(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)),
                     2'($urandom_range(0, 3)), $urandom, 1'b0);
                bus1.wb_wreg = ($urandom_range(0, 7) != 0);
                if ($urandom_range(0, 1) == 0) bus1.rs1_addr = bus1.wb_rd;
                if ($urandom_range(0, 2) == 0) bus1.rs2_addr = bus1.wb_rd;
                for (int w = 0; w < waitn; w++) begin
                    bus1.dm_rdata = $urandom;
                    step();
                end
                bus1.dm_rdata = $urandom; bus1.dm_rvalid = 1'b1;
                step();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
